// File: rtl/ic_pkg.sv
// ic_pkg: shared definitions for the CPU bus interconnect.
//   - Master IDs carried through the outstanding-response FIFO
//   - Bus field widths and the packed request payload
package ic_pkg;

    localparam int unsigned IC_ADDR_W = 32;
    localparam int unsigned IC_DATA_W = 32;
    localparam int unsigned IC_STRB_W = 4;

    localparam logic IC_ID_IMEM = 1'b0;
    localparam logic IC_ID_DMEM = 1'b1;

    // Request fields that travel together from the winning master to the bridge.
    typedef struct packed {
        logic                 wen;
        logic [IC_STRB_W-1:0] strb;
        logic [IC_DATA_W-1:0] wdata;
        logic [IC_ADDR_W-1:0] addr;
    } ic_req_t;

endpackage

// File: rtl/ic_id_fifo.sv
// ic_id_fifo: small synchronous FIFO recording which master owns each
// outstanding request.
// Ports:
//   g_clk, g_resetn   clock, asynchronous active-low reset (empties FIFO)
//   push, wdata       enqueue (ignored while full)
//   pop               dequeue head (ignored while empty)
//   rdata             head entry
//   full, empty       flags decoded from the registered occupancy
module ic_id_fifo #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned WIDTH = 1
) (
    input  logic             g_clk,
    input  logic             g_resetn,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    // Pointer advance with explicit wrap so any DEPTH (including 1) is safe.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(DEPTH - 1)) begin
            return '0;
        end
        return p + PTR_W'(1);
    endfunction

    // Pointers and occupancy.
    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (pop_ok) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: entries are only read when count says valid.
    always_ff @(posedge g_clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= wdata;
        end
    end

endmodule

// File: rtl/ic_cpu_bus_arbiter.sv
// ic_cpu_bus_arbiter: merges the core's instruction (imem) and data (dmem)
// request/response channels onto the single port of the CPU-bus-to-BRAM
// bridge. Arbitration and response routing are combinational (zero latency);
// an ID FIFO of depth OUTSTANDING routes each in-order response back to its
// issuing master.
// Ports:
//   g_clk, g_resetn                 clock, asynchronous active-low reset
//   imem_* / dmem_*                 master request (req/gnt/wen/strb/wdata/addr)
//                                   and response (recv/ack/error/rdata)
//   s_*                             bridge-side request and response
// Build option:
//   IC_ARB_ROUND_ROBIN_EN  defined   -> conflicts alternate (last-winner flag)
//                          undefined -> fixed priority, dmem wins conflicts
module ic_cpu_bus_arbiter
    import ic_pkg::*;
#(
    parameter int unsigned OUTSTANDING = 2
) (
    input  logic                 g_clk,
    input  logic                 g_resetn,

    input  logic                 imem_req,
    output logic                 imem_gnt,
    input  logic                 imem_wen,
    input  logic [IC_STRB_W-1:0] imem_strb,
    input  logic [IC_DATA_W-1:0] imem_wdata,
    input  logic [IC_ADDR_W-1:0] imem_addr,
    output logic                 imem_recv,
    input  logic                 imem_ack,
    output logic                 imem_error,
    output logic [IC_DATA_W-1:0] imem_rdata,

    input  logic                 dmem_req,
    output logic                 dmem_gnt,
    input  logic                 dmem_wen,
    input  logic [IC_STRB_W-1:0] dmem_strb,
    input  logic [IC_DATA_W-1:0] dmem_wdata,
    input  logic [IC_ADDR_W-1:0] dmem_addr,
    output logic                 dmem_recv,
    input  logic                 dmem_ack,
    output logic                 dmem_error,
    output logic [IC_DATA_W-1:0] dmem_rdata,

    output logic                 s_req,
    input  logic                 s_gnt,
    output logic                 s_wen,
    output logic [IC_STRB_W-1:0] s_strb,
    output logic [IC_DATA_W-1:0] s_wdata,
    output logic [IC_ADDR_W-1:0] s_addr,
    input  logic                 s_recv,
    output logic                 s_ack,
    input  logic                 s_error,
    input  logic [IC_DATA_W-1:0] s_rdata
);

    logic    id_full;
    logic    id_empty;
    logic    head_id;
    logic    sel_dmem;
    logic    win_id;
    logic    req_accept;
    logic    rsp_accept;
    ic_req_t imem_pl;
    ic_req_t dmem_pl;
    ic_req_t s_pl;

    // ------------------------------------------------------------------
    // Winner selection
    // ------------------------------------------------------------------
`ifdef IC_ARB_ROUND_ROBIN_EN
    logic last_win;

    // Remember who won the last accepted request; reset favours imem next.
    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            last_win <= IC_ID_DMEM;
        end else if (req_accept) begin
            last_win <= win_id;
        end
    end

    assign sel_dmem = dmem_req && (!imem_req || (last_win == IC_ID_IMEM));
`else
    assign sel_dmem = dmem_req;
`endif

    assign win_id = sel_dmem ? IC_ID_DMEM : IC_ID_IMEM;

    // ------------------------------------------------------------------
    // Request path
    // ------------------------------------------------------------------
    assign imem_pl = '{wen: imem_wen, strb: imem_strb, wdata: imem_wdata, addr: imem_addr};
    assign dmem_pl = '{wen: dmem_wen, strb: dmem_strb, wdata: dmem_wdata, addr: dmem_addr};
    assign s_pl    = sel_dmem ? dmem_pl : imem_pl;

    assign s_wen   = s_pl.wen;
    assign s_strb  = s_pl.strb;
    assign s_wdata = s_pl.wdata;
    assign s_addr  = s_pl.addr;

    // A full ID FIFO blocks new requests even if a pop happens this cycle.
    assign s_req      = (imem_req || dmem_req) && !id_full;
    assign imem_gnt   = imem_req && !sel_dmem && s_gnt && !id_full;
    assign dmem_gnt   = sel_dmem && s_gnt && !id_full;
    assign req_accept = s_req && s_gnt;

    // ------------------------------------------------------------------
    // Response path: head of the ID FIFO owns the current response.
    // With nothing outstanding the response is acked and dropped.
    // ------------------------------------------------------------------
    assign imem_recv  = s_recv && !id_empty && (head_id == IC_ID_IMEM);
    assign dmem_recv  = s_recv && !id_empty && (head_id == IC_ID_DMEM);
    assign s_ack      = id_empty || ((head_id == IC_ID_DMEM) ? dmem_ack : imem_ack);
    assign rsp_accept = s_recv && s_ack && !id_empty;

    assign imem_error = s_error;
    assign dmem_error = s_error;
    assign imem_rdata = s_rdata;
    assign dmem_rdata = s_rdata;

    ic_id_fifo #(
        .DEPTH (OUTSTANDING),
        .WIDTH (1)
    ) u_id_fifo (
        .g_clk    (g_clk),
        .g_resetn (g_resetn),
        .push     (req_accept),
        .pop      (rsp_accept),
        .wdata    (win_id),
        .rdata    (head_id),
        .full     (id_full),
        .empty    (id_empty)
    );

`ifdef IC_ARB_ROUND_ROBIN_EN
    // A response with nothing outstanding indicates a bridge protocol error.
    a_no_orphan_rsp : assert property (
        @(posedge g_clk) disable iff (!g_resetn) !(s_recv && id_empty)
    ) else $error("ic_cpu_bus_arbiter: response received with no outstanding request");
`endif

endmodule

// File: tb/tb_ic_cpu_bus_arbiter.sv
// Directed self-checking bench for ic_cpu_bus_arbiter (OUTSTANDING = 2).
// Inputs change at the falling edge; combinational outputs are checked 1ns later.
module tb_ic_cpu_bus_arbiter;

    logic        g_clk;
    logic        g_resetn;
    logic        imem_req, imem_gnt, imem_wen, imem_recv, imem_ack, imem_error;
    logic [3:0]  imem_strb;
    logic [31:0] imem_wdata, imem_addr, imem_rdata;
    logic        dmem_req, dmem_gnt, dmem_wen, dmem_recv, dmem_ack, dmem_error;
    logic [3:0]  dmem_strb;
    logic [31:0] dmem_wdata, dmem_addr, dmem_rdata;
    logic        s_req, s_gnt, s_wen, s_recv, s_ack, s_error;
    logic [3:0]  s_strb;
    logic [31:0] s_wdata, s_addr, s_rdata;

    int checks;
    int failures;

    ic_cpu_bus_arbiter #(.OUTSTANDING(2)) dut (
        .g_clk(g_clk), .g_resetn(g_resetn),
        .imem_req(imem_req), .imem_gnt(imem_gnt), .imem_wen(imem_wen),
        .imem_strb(imem_strb), .imem_wdata(imem_wdata), .imem_addr(imem_addr),
        .imem_recv(imem_recv), .imem_ack(imem_ack), .imem_error(imem_error),
        .imem_rdata(imem_rdata),
        .dmem_req(dmem_req), .dmem_gnt(dmem_gnt), .dmem_wen(dmem_wen),
        .dmem_strb(dmem_strb), .dmem_wdata(dmem_wdata), .dmem_addr(dmem_addr),
        .dmem_recv(dmem_recv), .dmem_ack(dmem_ack), .dmem_error(dmem_error),
        .dmem_rdata(dmem_rdata),
        .s_req(s_req), .s_gnt(s_gnt), .s_wen(s_wen), .s_strb(s_strb),
        .s_wdata(s_wdata), .s_addr(s_addr), .s_recv(s_recv), .s_ack(s_ack),
        .s_error(s_error), .s_rdata(s_rdata)
    );

    initial begin
        g_clk = 1'b0;
        forever #5 g_clk = ~g_clk;
    end

    task automatic idle_inputs();
        imem_req = 0; imem_wen = 0; imem_strb = 4'h0; imem_wdata = '0; imem_addr = '0; imem_ack = 0;
        dmem_req = 0; dmem_wen = 0; dmem_strb = 4'h0; dmem_wdata = '0; dmem_addr = '0; dmem_ack = 0;
        s_gnt = 0; s_recv = 0; s_error = 0; s_rdata = '0;
    endtask

    task automatic test_reset();
        @(negedge g_clk);
        idle_inputs();
        g_resetn = 0;
        s_recv = 1;
        #1;
        checks++; if (imem_recv !== 1'b0) begin failures++; $display("FAIL reset_imem_recv got=%b exp=0", imem_recv); end
        checks++; if (dmem_recv !== 1'b0) begin failures++; $display("FAIL reset_dmem_recv got=%b exp=0", dmem_recv); end
        checks++; if (s_req !== 1'b0) begin failures++; $display("FAIL reset_s_req got=%b exp=0", s_req); end
        imem_req = 1;
        #1;
        checks++; if (s_req !== 1'b1) begin failures++; $display("FAIL reset_s_req_with_req got=%b exp=1", s_req); end
        @(negedge g_clk);
        idle_inputs();
        g_resetn = 1;
    endtask

    task automatic test_single_read();
        @(negedge g_clk);
        imem_req = 1; imem_addr = 32'h0000_0100; s_gnt = 1;
        #1;
        checks++; if (s_req !== 1'b1) begin failures++; $display("FAIL rd_s_req got=%b exp=1", s_req); end
        checks++; if (s_addr !== 32'h100) begin failures++; $display("FAIL rd_s_addr got=%h exp=00000100", s_addr); end
        checks++; if (imem_gnt !== 1'b1) begin failures++; $display("FAIL rd_imem_gnt got=%b exp=1", imem_gnt); end
        checks++; if (dmem_gnt !== 1'b0) begin failures++; $display("FAIL rd_dmem_gnt got=%b exp=0", dmem_gnt); end
        @(negedge g_clk);
        imem_req = 0; s_gnt = 0; s_recv = 1; s_rdata = 32'hDEAD_BEEF; imem_ack = 1;
        #1;
        checks++; if (imem_recv !== 1'b1) begin failures++; $display("FAIL rd_imem_recv got=%b exp=1", imem_recv); end
        checks++; if (imem_rdata !== 32'hDEAD_BEEF) begin failures++; $display("FAIL rd_imem_rdata got=%h exp=deadbeef", imem_rdata); end
        checks++; if (dmem_recv !== 1'b0) begin failures++; $display("FAIL rd_dmem_recv got=%b exp=0", dmem_recv); end
        checks++; if (s_ack !== 1'b1) begin failures++; $display("FAIL rd_s_ack got=%b exp=1", s_ack); end
        @(negedge g_clk);
        idle_inputs();
    endtask

    // Both masters request; each grant is answered before the next conflict.
    task automatic test_conflict();
        logic exp_dmem;
        @(negedge g_clk);
        g_resetn = 0;
        @(negedge g_clk);
        g_resetn = 1;
        for (int i = 0; i < 4; i++) begin
`ifdef IC_ARB_ROUND_ROBIN_EN
            exp_dmem = (i % 2) == 1;
`else
            exp_dmem = 1'b1;
`endif
            @(negedge g_clk);
            idle_inputs();
            imem_req = 1; dmem_req = 1; s_gnt = 1;
            imem_addr = 32'h1000; dmem_addr = 32'h2000;
            #1;
            checks++; if (dmem_gnt !== exp_dmem) begin failures++; $display("FAIL conflict_dmem_gnt[%0d] got=%b exp=%b", i, dmem_gnt, exp_dmem); end
            checks++; if (imem_gnt !== !exp_dmem) begin failures++; $display("FAIL conflict_imem_gnt[%0d] got=%b exp=%b", i, imem_gnt, !exp_dmem); end
            checks++; if (s_addr !== (exp_dmem ? 32'h2000 : 32'h1000)) begin failures++; $display("FAIL conflict_s_addr[%0d] got=%h exp=%h", i, s_addr, exp_dmem ? 32'h2000 : 32'h1000); end
            @(negedge g_clk);
            idle_inputs();
            s_recv = 1; imem_ack = 1; dmem_ack = 1;
            #1;
            checks++; if (dmem_recv !== exp_dmem) begin failures++; $display("FAIL conflict_dmem_recv[%0d] got=%b exp=%b", i, dmem_recv, exp_dmem); end
            checks++; if (imem_recv !== !exp_dmem) begin failures++; $display("FAIL conflict_imem_recv[%0d] got=%b exp=%b", i, imem_recv, !exp_dmem); end
        end
        @(negedge g_clk);
        idle_inputs();
    endtask

    // Fill the FIFO (imem, dmem), then a third imem request is blocked.
    task automatic test_full();
        @(negedge g_clk);
        imem_req = 1; s_gnt = 1;
        #1;
        checks++; if (imem_gnt !== 1'b1) begin failures++; $display("FAIL full_first_gnt got=%b exp=1", imem_gnt); end
        @(negedge g_clk);
        imem_req = 0; dmem_req = 1;
        #1;
        checks++; if (dmem_gnt !== 1'b1) begin failures++; $display("FAIL full_second_gnt got=%b exp=1", dmem_gnt); end
        @(negedge g_clk);
        dmem_req = 0; imem_req = 1; imem_addr = 32'h300;
        for (int i = 0; i < 2; i++) begin
            #1;
            checks++; if (imem_gnt !== 1'b0) begin failures++; $display("FAIL full_blocked_gnt[%0d] got=%b exp=0", i, imem_gnt); end
            checks++; if (s_req !== 1'b0) begin failures++; $display("FAIL full_blocked_s_req[%0d] got=%b exp=0", i, s_req); end
            @(negedge g_clk);
        end
        s_recv = 1; imem_ack = 1;
        #1;
        checks++; if (imem_recv !== 1'b1) begin failures++; $display("FAIL full_pop_recv got=%b exp=1", imem_recv); end
        checks++; if (imem_gnt !== 1'b0) begin failures++; $display("FAIL full_pop_same_cycle_gnt got=%b exp=0", imem_gnt); end
        @(negedge g_clk);
        s_recv = 0; imem_ack = 0;
        #1;
        checks++; if (imem_gnt !== 1'b1) begin failures++; $display("FAIL full_after_pop_gnt got=%b exp=1", imem_gnt); end
        checks++; if (s_req !== 1'b1) begin failures++; $display("FAIL full_after_pop_s_req got=%b exp=1", s_req); end
        @(negedge g_clk);
        idle_inputs();
    endtask

    // FIFO now holds (dmem, imem); stall the dmem response for three cycles.
    task automatic test_ack_stall();
        for (int i = 0; i < 3; i++) begin
            @(negedge g_clk);
            s_recv = 1; s_rdata = 32'hA5A5_0000 + 32'(i); dmem_ack = 0; imem_ack = 1;
            #1;
            checks++; if (s_ack !== 1'b0) begin failures++; $display("FAIL stall_s_ack[%0d] got=%b exp=0", i, s_ack); end
            checks++; if (dmem_recv !== 1'b1) begin failures++; $display("FAIL stall_dmem_recv[%0d] got=%b exp=1", i, dmem_recv); end
            checks++; if (imem_recv !== 1'b0) begin failures++; $display("FAIL stall_imem_recv[%0d] got=%b exp=0", i, imem_recv); end
        end
        @(negedge g_clk);
        dmem_ack = 1;
        #1;
        checks++; if (s_ack !== 1'b1) begin failures++; $display("FAIL stall_release_s_ack got=%b exp=1", s_ack); end
        checks++; if (dmem_recv !== 1'b1) begin failures++; $display("FAIL stall_release_dmem_recv got=%b exp=1", dmem_recv); end
        @(negedge g_clk);
        dmem_ack = 0; imem_ack = 1;
        #1;
        checks++; if (imem_recv !== 1'b1) begin failures++; $display("FAIL stall_next_imem_recv got=%b exp=1", imem_recv); end
        checks++; if (dmem_recv !== 1'b0) begin failures++; $display("FAIL stall_next_dmem_recv got=%b exp=0", dmem_recv); end
        @(negedge g_clk);
        idle_inputs();
    endtask

    task automatic test_write();
        @(negedge g_clk);
        dmem_req = 1; dmem_wen = 1; dmem_strb = 4'b0011; dmem_wdata = 32'h1234_5678;
        dmem_addr = 32'h200; s_gnt = 1;
        #1;
        checks++; if (s_wen !== 1'b1) begin failures++; $display("FAIL wr_s_wen got=%b exp=1", s_wen); end
        checks++; if (s_strb !== 4'b0011) begin failures++; $display("FAIL wr_s_strb got=%b exp=0011", s_strb); end
        checks++; if (s_wdata !== 32'h1234_5678) begin failures++; $display("FAIL wr_s_wdata got=%h exp=12345678", s_wdata); end
        checks++; if (dmem_gnt !== 1'b1) begin failures++; $display("FAIL wr_dmem_gnt got=%b exp=1", dmem_gnt); end
        @(negedge g_clk);
        idle_inputs();
        s_recv = 1; s_error = 1; dmem_ack = 1;
        #1;
        checks++; if (dmem_recv !== 1'b1) begin failures++; $display("FAIL wr_dmem_recv got=%b exp=1", dmem_recv); end
        checks++; if (dmem_error !== 1'b1) begin failures++; $display("FAIL wr_dmem_error got=%b exp=1", dmem_error); end
        checks++; if (imem_recv !== 1'b0) begin failures++; $display("FAIL wr_imem_recv got=%b exp=0", imem_recv); end
        @(negedge g_clk);
        idle_inputs();
    endtask

    task automatic test_reset_midflight();
        @(negedge g_clk);
        imem_req = 1; s_gnt = 1;
        @(negedge g_clk);
        imem_req = 0; dmem_req = 1;
        @(negedge g_clk);
        dmem_req = 0; imem_req = 1;
        #1;
        checks++; if (imem_gnt !== 1'b0) begin failures++; $display("FAIL mid_full_before_reset got=%b exp=0", imem_gnt); end
        g_resetn = 0;
        #1;
        checks++; if (imem_gnt !== 1'b1) begin failures++; $display("FAIL mid_gnt_in_reset got=%b exp=1", imem_gnt); end
        imem_req = 0;
        @(negedge g_clk);
        g_resetn = 1;
`ifndef IC_ARB_ROUND_ROBIN_EN
        s_recv = 1; imem_ack = 0; dmem_ack = 0;
        #1;
        checks++; if (s_ack !== 1'b1) begin failures++; $display("FAIL mid_drop_s_ack got=%b exp=1", s_ack); end
        checks++; if (imem_recv !== 1'b0) begin failures++; $display("FAIL mid_drop_imem_recv got=%b exp=0", imem_recv); end
        checks++; if (dmem_recv !== 1'b0) begin failures++; $display("FAIL mid_drop_dmem_recv got=%b exp=0", dmem_recv); end
`endif
        @(negedge g_clk);
        idle_inputs();
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        g_resetn = 1;
        idle_inputs();
        test_reset();
        test_single_read();
        test_conflict();
        test_full();
        test_ack_stall();
        test_write();
        test_reset_midflight();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
